// File: rtl/alu_status_writeback.sv
// Commit stage behind the SPARC V8 ALU: holds icc, Y and a one-entry result buffer,
// latches tagged-arithmetic traps, performs the delayed WRY write and evaluates Bicc.
module alu_status_writeback #(
    parameter int          WRY_DELAY = 3,
    parameter logic [31:0] RESET_Y   = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [5:0]  i_op,
    input  logic [31:0] i_res,
    input  logic [31:0] i_y_in,
    input  logic        i_n_in,
    input  logic        i_z_in,
    input  logic        i_v_in,
    input  logic        i_c_in,
    input  logic        i_trap_in,
    input  logic        i_wry_valid,
    input  logic [31:0] i_wry_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_result,
    output logic [3:0]  o_icc,
    output logic        o_cin_out,
    output logic [31:0] o_y_reg,
    output logic        o_trap_pending,
    input  logic        i_trap_ack,
    input  logic [3:0]  i_cond,
    output logic        o_taken
);

    localparam int CW = (WRY_DELAY < 2) ? 1 : $clog2(WRY_DELAY + 1);

    logic [3:0]    r_icc;
    logic [31:0]   r_y;
    logic [31:0]   r_result;
    logic          r_out_valid;
    logic          r_trap_pending;
    logic          r_wry_pending;
    logic [CW-1:0] r_wry_cnt;
    logic [31:0]   r_wry_data;

    logic [63:0]   w_icc_op_map;
    logic [63:0]   w_mul_op_map;
    logic          w_tag_trap_op;
    logic          w_tag_cc_op;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_trap_accept;
    logic          w_result_load;
    logic          w_icc_write;
    logic          w_mul_y_write;
    logic          w_wry_expire;
    logic          w_n;
    logic          w_z;
    logic          w_v;
    logic          w_c;
    logic [7:0]    w_cond_true;

    // Opcode classification tables, one bit per 6-bit ALU opcode.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_op_map
            assign w_icc_op_map[gi] = (((gi >= 16) && (gi <= 24)) || (gi == 26) || (gi == 27) ||
                                       (gi == 28) || ((gi >= 32) && (gi <= 35))) ? 1'b1 : 1'b0;
            assign w_mul_op_map[gi] = ((gi == 10) || (gi == 11) || (gi == 26) || (gi == 27)) ? 1'b1 : 1'b0;
        end
    endgenerate

    assign w_tag_trap_op = (i_op == 6'd34) || (i_op == 6'd35);
    assign w_tag_cc_op   = (i_op == 6'd32) || (i_op == 6'd33);

    assign w_in_ready    = !r_trap_pending && (!r_out_valid || i_out_ready);
    assign w_accept      = i_in_valid && w_in_ready;
    assign w_trap_accept = w_accept && i_trap_in && w_tag_trap_op;
    assign w_result_load = w_accept && !w_trap_accept;
    // TADDcc/TSUBcc still commit flags when the tag check fails; other cc ops need a clean bundle.
    assign w_icc_write   = w_result_load && w_icc_op_map[i_op] && (!i_trap_in || w_tag_cc_op);
    assign w_mul_y_write = w_accept && w_mul_op_map[i_op];
    // A count of 1 (or 0 when WRY_DELAY is 0) means this edge is the commit edge.
    assign w_wry_expire  = r_wry_pending && !i_wry_valid && (r_wry_cnt <= CW'(1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_result    <= 32'h0;
        end else if (w_result_load) begin
            r_out_valid <= 1'b1;
            r_result    <= i_res;
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_icc <= 4'h0;
        end else if (w_icc_write) begin
            r_icc <= {i_n_in, i_z_in, i_v_in, i_c_in};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_trap_pending <= 1'b0;
        end else if (w_trap_accept) begin
            r_trap_pending <= 1'b1;
        end else if (i_trap_ack) begin
            r_trap_pending <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wry_pending <= 1'b0;
            r_wry_cnt     <= '0;
            r_wry_data    <= 32'h0;
        end else if (i_wry_valid) begin
            r_wry_pending <= 1'b1;
            r_wry_cnt     <= CW'(WRY_DELAY);
            r_wry_data    <= i_wry_data;
        end else if (r_wry_pending) begin
            if (r_wry_cnt <= CW'(1)) begin
                r_wry_pending <= 1'b0;
            end else begin
                r_wry_cnt <= r_wry_cnt - CW'(1);
            end
        end
    end

    // An expiring WRY overrides a multiply writing Y on the same edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_y <= RESET_Y;
        end else if (w_wry_expire) begin
            r_y <= r_wry_data;
        end else if (w_mul_y_write) begin
            r_y <= i_y_in;
        end
    end

    assign w_n = r_icc[3];
    assign w_z = r_icc[2];
    assign w_v = r_icc[1];
    assign w_c = r_icc[0];

    // Conditions 0..7; cond[3] selects the complementary test.
    assign w_cond_true = {w_v, w_n, w_c, w_c | w_z, w_n ^ w_v, w_z | (w_n ^ w_v), w_z, 1'b0};

    assign o_taken        = i_cond[3] ^ w_cond_true[i_cond[2:0]];
    assign o_in_ready     = w_in_ready;
    assign o_out_valid    = r_out_valid;
    assign o_result       = r_result;
    assign o_icc          = r_icc;
    assign o_cin_out      = r_icc[0];
    assign o_y_reg        = r_y;
    assign o_trap_pending = r_trap_pending;

endmodule

// File: tb/tb_alu_status_writeback.sv
// Directed bench for alu_status_writeback: an abstract per-edge model is compared on every
// falling edge, and literal expectations from hand-worked scenarios pin the model.
module tb_alu_status_writeback;

    localparam int WD     = 3;
    localparam int WD_EFF = (WD == 0) ? 1 : WD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  op = 6'd0;
    logic [31:0] res = 32'h0;
    logic [31:0] y_in = 32'h0;
    logic        n_in = 1'b0, z_in = 1'b0, v_in = 1'b0, c_in = 1'b0;
    logic        trap_in = 1'b0;
    logic        wry_valid = 1'b0;
    logic [31:0] wry_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [3:0]  icc;
    logic        cin_out;
    logic [31:0] y_reg;
    logic        trap_pending;
    logic        trap_ack = 1'b0;
    logic [3:0]  cond = 4'd0;
    logic        taken;

    int n_checks = 0;
    int n_fail   = 0;

    alu_status_writeback #(.WRY_DELAY(WD), .RESET_Y(32'h0)) dut (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_op(op), .i_res(res), .i_y_in(y_in),
        .i_n_in(n_in), .i_z_in(z_in), .i_v_in(v_in), .i_c_in(c_in), .i_trap_in(trap_in),
        .i_wry_valid(wry_valid), .i_wry_data(wry_data),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_result(result),
        .o_icc(icc), .o_cin_out(cin_out), .o_y_reg(y_reg), .o_trap_pending(trap_pending),
        .i_trap_ack(trap_ack), .i_cond(cond), .o_taken(taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]  m_icc = 4'h0;
    logic [31:0] m_y = 32'h0;
    logic [31:0] m_res = 32'h0;
    logic        m_ov = 1'b0;
    logic        m_trap = 1'b0;
    logic        m_wpend = 1'b0;
    logic [31:0] m_wdata = 32'h0;
    int          m_wdue = 0;
    int          cyc = 0;

    function automatic bit is_cc_op(input logic [5:0] o);
        int v;
        v = int'(o);
        return (v >= 16 && v <= 24) || v == 26 || v == 27 || v == 28 || (v >= 32 && v <= 35);
    endfunction

    function automatic bit is_mul_op(input logic [5:0] o);
        int v;
        v = int'(o);
        return v == 10 || v == 11 || v == 26 || v == 27;
    endfunction

    function automatic bit m_taken(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, v, c, b;
        n = f[3]; z = f[2]; v = f[1]; c = f[0];
        case (cc[2:0])
            3'd0: b = 1'b0;
            3'd1: b = z;
            3'd2: b = z | (n ^ v);
            3'd3: b = n ^ v;
            3'd4: b = c | z;
            3'd5: b = c;
            3'd6: b = n;
            default: b = v;
        endcase
        return cc[3] ? !b : b;
    endfunction

    wire m_rdy  = !m_trap && (!m_ov || out_ready);
    wire m_acc  = in_valid && m_rdy;
    wire m_tacc = m_acc && trap_in && (op == 6'd34 || op == 6'd35);
    wire m_wexp = m_wpend && !wry_valid && ((cyc + 1) == m_wdue);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_icc   <= 4'h0;
            m_y     <= 32'h0;
            m_res   <= 32'h0;
            m_ov    <= 1'b0;
            m_trap  <= 1'b0;
            m_wpend <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (m_acc)
                $display("accept op=%0d res=%h flags=%b trap_in=%0b", op, res, {n_in, z_in, v_in, c_in}, trap_in);
            if (m_acc && !m_tacc) begin
                m_ov  <= 1'b1;
                m_res <= res;
            end else if (out_ready) begin
                m_ov <= 1'b0;
            end
            if (m_acc && !m_tacc && is_cc_op(op) && (!trap_in || op == 6'd32 || op == 6'd33))
                m_icc <= {n_in, z_in, v_in, c_in};
            if (m_wexp)
                m_y <= m_wdata;
            else if (m_acc && is_mul_op(op))
                m_y <= y_in;
            if (wry_valid) begin
                m_wpend <= 1'b1;
                m_wdata <= wry_data;
                m_wdue  <= cyc + 1 + WD_EFF;
            end else if (m_wexp) begin
                m_wpend <= 1'b0;
            end
            if (m_tacc)
                m_trap <= 1'b1;
            else if (trap_ack)
                m_trap <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cmp_out_valid", 32'(out_valid), 32'(m_ov));
        chk("cmp_result", result, m_res);
        chk("cmp_icc", 32'(icc), 32'(m_icc));
        chk("cmp_cin", 32'(cin_out), 32'(m_icc[0]));
        chk("cmp_y", y_reg, m_y);
        chk("cmp_trap", 32'(trap_pending), 32'(m_trap));
        chk("cmp_in_ready", 32'(in_ready), 32'(m_rdy));
        chk("cmp_taken", 32'(taken), 32'(m_taken(cond, m_icc)));
    end

    // ---------------- directed stimulus ----------------
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic bundle(input logic [5:0] o, input logic [31:0] r, input logic [3:0] f,
                          input logic t, input logic [31:0] y);
        in_valid = 1'b1;
        op = o; res = r; y_in = y; trap_in = t;
        {n_in, z_in, v_in, c_in} = f;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        trap_in  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sequence did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("reset_icc", 32'(icc), 32'h0);
        chk("reset_y", y_reg, 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_result", result, 32'h0);
        chk("reset_trap", 32'(trap_pending), 32'h0);
        edge1();
        edge1();
        #2 reset = 1'b0;

        // flag commit and branch evaluation
        bundle(6'd16, 32'h0, 4'b0100, 1'b0, 32'h0);
        edge1();
        chk("c1_icc", 32'(icc), 32'h4);
        chk("c1_out_valid", 32'(out_valid), 32'h1);
        chk("c1_result", result, 32'h0);
        idle();
        cond = 4'd1;
        #1 chk("c1_taken_be", 32'(taken), 32'h1);
        cond = 4'd9;
        #1 chk("c1_taken_bne", 32'(taken), 32'h0);

        // non-updating op, then carry feedback
        bundle(6'd0, 32'h7, 4'b1111, 1'b0, 32'h0);
        edge1();
        chk("c2_icc_hold", 32'(icc), 32'h4);
        chk("c2_result", result, 32'h7);
        bundle(6'd24, 32'h8, 4'b0001, 1'b0, 32'h0);
        edge1();
        chk("c2_cin", 32'(cin_out), 32'h1);
        chk("c2_icc", 32'(icc), 32'h1);

        // multiply Y write and delayed WRY
        bundle(6'd26, 32'h9, 4'b0010, 1'b0, 32'h5);
        edge1();
        chk("c3_y_mul", y_reg, 32'h5);
        chk("c3_icc", 32'(icc), 32'h2);
        idle();
        wry_valid = 1'b1; wry_data = 32'hDEAD_BEEF;
        edge1();
        wry_valid = 1'b0;
        edge1();
        chk("c3_wry_e1", y_reg, 32'h5);
        edge1();
        chk("c3_wry_e2", y_reg, 32'h5);
        edge1();
        chk("c3_wry_e3", y_reg, 32'hDEAD_BEEF);

        wry_valid = 1'b1; wry_data = 32'hCAFE_F00D;
        edge1();
        wry_valid = 1'b0;
        edge1();
        edge1();
        chk("c3_wry2_e2", y_reg, 32'hDEAD_BEEF);
        bundle(6'd10, 32'h3, 4'b1111, 1'b0, 32'h77);
        edge1();
        chk("c3_wry_wins", y_reg, 32'hCAFE_F00D);
        chk("c3_icc_mul_nocc", 32'(icc), 32'h2);
        chk("c3_result", result, 32'h3);
        idle();

        // WRY restart replaces data and timing
        wry_valid = 1'b1; wry_data = 32'h1;
        edge1();
        wry_data = 32'h2;
        edge1();
        wry_valid = 1'b0;
        edge1();
        edge1();
        chk("c3_restart_hold", y_reg, 32'hCAFE_F00D);
        edge1();
        chk("c3_restart_write", y_reg, 32'h2);

        // tag-overflow trap
        chk("c4_pre_out_valid", 32'(out_valid), 32'h0);
        bundle(6'd34, 32'h1234, 4'b1111, 1'b1, 32'h0);
        edge1();
        chk("c4_out_valid", 32'(out_valid), 32'h0);
        chk("c4_icc", 32'(icc), 32'h2);
        chk("c4_trap", 32'(trap_pending), 32'h1);
        chk("c4_in_ready", 32'(in_ready), 32'h0);
        bundle(6'd16, 32'hAA, 4'b1000, 1'b0, 32'h0);
        edge1();
        chk("c4_blocked", 32'(out_valid), 32'h0);
        edge1();
        chk("c4_trap_hold", 32'(trap_pending), 32'h1);
        trap_ack = 1'b1;
        edge1();
        trap_ack = 1'b0;
        chk("c4_trap_clr", 32'(trap_pending), 32'h0);
        chk("c4_ack_noaccept", 32'(out_valid), 32'h0);
        chk("c4_ready_back", 32'(in_ready), 32'h1);
        edge1();
        chk("c4_accept_ov", 32'(out_valid), 32'h1);
        chk("c4_accept_res", result, 32'hAA);
        chk("c4_accept_icc", 32'(icc), 32'h8);

        // TADDcc with trap_in still commits flags
        bundle(6'd32, 32'h55, 4'b0011, 1'b1, 32'h0);
        edge1();
        chk("c4_tadd_icc", 32'(icc), 32'h3);
        chk("c4_tadd_notrap", 32'(trap_pending), 32'h0);
        chk("c4_tadd_res", result, 32'h55);
        idle();

        // branch sweep against icc=0011
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1 cond = 4'(k);
            #1 chk("taken_sweep", 32'(taken), 32'(m_taken(4'(k), m_icc)));
        end
        cond = 4'd3;
        #1 chk("taken_bl", 32'(taken), 32'h1);
        cond = 4'd6;
        #1 chk("taken_bneg", 32'(taken), 32'h0);

        // backpressure
        edge1();
        out_ready = 1'b0;
        bundle(6'd0, 32'h1, 4'b0000, 1'b0, 32'h0);
        edge1();
        chk("c5_res1", result, 32'h1);
        chk("c5_ov", 32'(out_valid), 32'h1);
        chk("c5_stall", 32'(in_ready), 32'h0);
        bundle(6'd0, 32'h2, 4'b0000, 1'b0, 32'h0);
        edge1();
        chk("c5_res1_held", result, 32'h1);
        chk("c5_stall2", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1 chk("c5_ready", 32'(in_ready), 32'h1);
        edge1();
        chk("c5_res2", result, 32'h2);
        chk("c5_ov2", 32'(out_valid), 32'h1);
        idle();
        edge1();
        chk("c5_drain", 32'(out_valid), 32'h0);

        // async reset with trap and WRY pending
        bundle(6'd35, 32'h99, 4'b1111, 1'b1, 32'h0);
        edge1();
        chk("c6_trap_set", 32'(trap_pending), 32'h1);
        idle();
        wry_valid = 1'b1; wry_data = 32'h1111;
        edge1();
        wry_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("c6_rst_trap", 32'(trap_pending), 32'h0);
        chk("c6_rst_y", y_reg, 32'h0);
        chk("c6_rst_icc", 32'(icc), 32'h0);
        chk("c6_rst_ready", 32'(in_ready), 32'h1);
        edge1();
        #2 reset = 1'b0;
        repeat (5) edge1();
        chk("c6_no_wry", y_reg, 32'h0);

        // async reset with a buffered result and WRY pending
        out_ready = 1'b0;
        bundle(6'd0, 32'h9, 4'b0000, 1'b0, 32'h0);
        edge1();
        chk("c6b_ov", 32'(out_valid), 32'h1);
        idle();
        wry_valid = 1'b1; wry_data = 32'h2222;
        edge1();
        wry_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("c6b_rst_ov", 32'(out_valid), 32'h0);
        chk("c6b_rst_res", result, 32'h0);
        edge1();
        #2 reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) edge1();
        chk("c6b_no_wry", y_reg, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_status_writeback.md
Name: alu_status_writeback

Overview:
- Stage directly downstream of the SPARC V8 ALU. Consumes the ALU's result, N/Z/V/C, yRegO and trap outputs.
- Commits the integer condition codes (icc) and the Y register, and feeds icc.C (Cin) and Y (yRegI) back into the ALU.
- Buffers the 32-bit result in a one-entry register toward register-file writeback.
- Latches tagged-arithmetic traps, implements the delayed WRY write, and evaluates the Bicc condition from the committed icc.

Parameters:
- WRY_DELAY, 3, number of clock edges after WRY acceptance before Y takes the new value (0 = next edge).
- RESET_Y, 32'h0, reset value of the Y register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU output bundle valid.
- in_ready  out  1  stage can accept the bundle.
- op  in  6  ALU opcode of the bundle.
- res  in  32  ALU result.
- y_in  in  32  ALU yRegO (multiply high word).
- n_in, z_in, v_in, c_in  in  1 each  ALU flags.
- trap_in  in  1  ALU tag-overflow trap.
- wry_valid  in  1  WRY instruction strobe (single cycle).
- wry_data  in  32  WRY value.
- out_valid  out  1  result register holds data for writeback.
- out_ready  in  1  writeback consumes result.
- result  out  32  buffered result.
- icc  out  4  committed {N,Z,V,C}.
- cin_out  out  1  icc.C, drives ALU Cin.
- y_reg  out  32  committed Y, drives ALU yRegI.
- trap_pending  out  1  trap latched, awaiting ack.
- trap_ack  in  1  trap handler acknowledge.
- cond  in  4  Bicc cond field.
- taken  out  1  condition true for the committed icc (combinational).

Behaviour:
Reset (asynchronous, immediate):
- icc=0, y_reg=RESET_Y, out_valid=0, result=0, trap_pending=0.
- WRY counter idle, no pending WRY.

Handshake:
- in_ready = !trap_pending && (!out_valid || out_ready).
- A bundle is accepted on a rising edge with in_valid && in_ready.
- Result latency is 1 cycle: result and out_valid are set on the accepting edge.
- out_valid clears on an edge with out_ready && no new acceptance.
- Back-to-back acceptance with out_ready=1 sustains one result per cycle.

icc update at acceptance (trap_in=0 required):
- Updating ops: 16–24, 26, 27, 28 and 32–35. The new icc is {n_in,z_in,v_in,c_in}.
- Ops 0–15, 25, 29, 30, 31 and 36–39 leave icc unchanged.
- 32/33 (TADDcc/TSUBcc) update icc even if trap_in=1.

Trap:
- Accepting op 34 or 35 with trap_in=1:
  - icc and result are not written and out_valid is not set.
  - trap_pending=1 on that edge.
- trap_pending holds until an edge with trap_ack=1, then clears.
- in_ready=0 while trap_pending is set.
- trap_in on any other op is ignored.

Y from multiply:
- Accepting ops 10, 11, 26 or 27 writes y_reg=y_in on the same edge.
- This happens regardless of the cc variant.

WRY:
- wry_valid loads the counter with WRY_DELAY and captures wry_data. Pending is set.
- The counter decrements each edge. On the edge where it reaches 0 with pending set, y_reg=captured data and pending clears.
- With WRY_DELAY=0, the write happens on the edge after wry_valid.
- A new wry_valid while pending restarts the counter and replaces the captured data.
- If WRY expiry and a multiply Y write fall on the same edge, the WRY value wins.
- WRY is not blocked by trap_pending.

Branch (Bicc, from committed icc only):
- cond 8 = always; 0 = never.
- 9: !Z. 1: Z.
- 10: !(Z|(N^V)). 2: Z|(N^V).
- 11: !(N^V). 3: N^V.
- 12: !(C|Z). 4: C|Z.
- 13: !C. 5: C.
- 14: !N. 6: N.
- 15: !V. 7: V.

Reset mid-operation:
- Discards the buffered result, the pending WRY and the trap.

Test Plan:
- Reset, then accept op 16 with res=0, z_in=1, others 0 -> next edge icc=4'b0100, out_valid=1, result=0; cond=1 -> taken=1; cond=9 -> taken=0.
- Accept op 0 with flags 1111 after the previous case -> icc stays 4'b0100; op 24 with c_in=1 -> cin_out=1.
- Accept op 26, y_in=32'h0000_0005 -> y_reg=5 on the accepting edge. Pulse wry_valid, wry_data=32'hDEAD_BEEF, WRY_DELAY=3 -> y_reg=5 for two edges, =32'hDEAD_BEEF on the third edge. Repeat with a multiply accepted on the third edge -> WRY value wins.
- Accept op 34 with trap_in=1, res=32'h1234 -> out_valid stays 0, icc unchanged, trap_pending=1, in_ready=0. A held in_valid is not accepted until the edge with trap_ack=1; acceptance occurs the following cycle.
- out_ready=0 with two valid bundles (res=1, then res=2) -> first accepted, in_ready=0, result=1 held. Raising out_ready -> result=2 next edge; no loss or duplication.
- Assert reset asynchronously mid-cycle with out_valid=1, trap_pending=1 and WRY pending -> all outputs return to reset values immediately; no Y write after reset release.
